bus_register_bank: RTL

- Parametrised bank of NUM_REGS registers, each WIDTH bits wide, sharing one internal transfer bus.
- A small sequencer executes LOAD, MOVE, CLEAR and (optionally) SWAP commands, one bus transfer per cycle.
- Any register can be driven onto an external tri-state output bus.
- Sits in the datapath as the general-purpose register set between the control unit and the ALU bus.

---
 rtl/regbank_pkg.sv | 19 +
 rtl/bus_register_bank_if.sv | 33 +++
 rtl/regbank_cell.sv | 30 +++
 rtl/bus_register_bank.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared opcode constants and sequencer state encoding for the register bank.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regbank_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER1 = 3'd1,
        ST_XFER2 = 3'd2,
        ST_XFER3 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bus_register_bank_if.sv
// Command, readout and status signals between a controller and the register bank.
// Latency: none (wiring only).
// Backpressure: cmd_valid/cmd_ready; a request is held until cmd_ready is seen.
// master: drives cmd_*, data_in, out_en, out_sel; slave: drives cmd_ready, stored_flat, done, err.
interface bus_register_bank_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_op;
    logic [IDX_W-1:0]          cmd_dst;
    logic [IDX_W-1:0]          cmd_src;
    logic [WIDTH-1:0]          data_in;
    logic                      out_en;
    logic [IDX_W-1:0]          out_sel;
    logic [NUM_REGS*WIDTH-1:0] stored_flat;
    logic                      done;
    logic                      err;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, data_in, out_en, out_sel,
        input  cmd_ready, stored_flat, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, data_in, out_en, out_sel,
        output cmd_ready, stored_flat, done, err
    );

endinterface

// File: rtl/regbank_cell.sv
// One WIDTH-bit storage register with load enable and async active-low clear.
// Latency: loaded value visible on q_o the cycle after the load edge.
// Backpressure: none; loads whenever ld_en_i is high.
// Ports: clk, rst_n, ld_en_i, ld_dat_i[WIDTH], q_o[WIDTH].
module regbank_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_en_i,
    input  logic [WIDTH-1:0] ld_dat_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign q_d = ld_en_i ? ld_dat_i : q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bus_register_bank.sv
// Register bank with a one-transfer-per-cycle sequencer (LOAD/MOVE/CLEAR, optional SWAP).
// Latency: done 2 cycles after accept (4 for SWAP); cmd_ready returns the cycle after done.
// Backpressure: cmd_ready low while a command is in flight; waiting requests are held, never dropped.
// Ports: clk, reset (async active-low), bif (slave: command/readout/status), bus_out (tri-state readout).
// Macro REGBANK_SWAP_EN: when defined, adds the TMP register and the 3-transfer SWAP; otherwise op 10 is illegal.
module bus_register_bank
    import regbank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_register_bank_if.slave   bif,
    output wire  [WIDTH-1:0]     bus_out
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int IW1   = IDX_W + 1;
    localparam logic [IDX_W:0] NUM_REGS_C = IW1'(NUM_REGS);

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] dst_q, src_q;
    logic [WIDTH-1:0] data_q;

    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic                wr_vld;
    logic [WIDTH-1:0]    xbus;      // internal transfer bus, one source per XFER cycle
    logic [WIDTH-1:0]    src_rd, dst_rd, sel_rd;
    logic [NUM_REGS*WIDTH-1:0] flat;
    logic                cmd_ill;
    logic                accept;

`ifdef REGBANK_SWAP_EN
    logic [WIDTH-1:0] tmp_q;
    logic             tmp_ld;
`endif

    // Widened compare so a power-of-two bank does not produce a constant comparison.
    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < NUM_REGS_C;
    endfunction

    assign bif.cmd_ready = (state_q == ST_IDLE) && reset;
    assign accept        = bif.cmd_valid && bif.cmd_ready;
    assign bif.done      = (state_q == ST_DONE);
    assign bif.err       = bif.done && cmd_ill;

    // Read muxes; an out-of-range index matches no register and reads 0.
    always_comb begin
        src_rd = '0;
        dst_rd = '0;
        sel_rd = '0;
        flat   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_q == IDX_W'(i))       src_rd = regs[i];
            if (dst_q == IDX_W'(i))       dst_rd = regs[i];
            if (bif.out_sel == IDX_W'(i)) sel_rd = regs[i];
            flat[i*WIDTH +: WIDTH] = regs[i];
        end
    end

    assign bif.stored_flat = flat;
    assign bus_out = bif.out_en ? sel_rd : {WIDTH{1'bz}};

    // Judged on the latched command, so it stays stable through to DONE.
    always_comb begin
        cmd_ill = 1'b0;
        case (op_q)
            OP_LOAD, OP_CLEAR: cmd_ill = !in_range(dst_q);
            OP_MOVE:           cmd_ill = !(in_range(dst_q) && in_range(src_q));
            default: begin
`ifdef REGBANK_SWAP_EN
                cmd_ill = !(in_range(dst_q) && in_range(src_q));
`else
                cmd_ill = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        wr_vld  = 1'b0;
        wr_idx  = dst_q;
        xbus    = '0;
`ifdef REGBANK_SWAP_EN
        tmp_ld  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_XFER1;
            end
            ST_XFER1: begin
                state_d = ST_DONE;
                case (op_q)
                    OP_LOAD:  begin xbus = data_q; wr_vld = 1'b1; end
                    OP_MOVE:  begin xbus = src_rd; wr_vld = 1'b1; end
                    OP_CLEAR: begin xbus = '0;     wr_vld = 1'b1; end
                    default: begin
`ifdef REGBANK_SWAP_EN
                        xbus    = src_rd;
                        tmp_ld  = 1'b1;
                        state_d = ST_XFER2;
`endif
                    end
                endcase
            end
`ifdef REGBANK_SWAP_EN
            ST_XFER2: begin
                xbus    = dst_rd;
                wr_idx  = src_q;
                wr_vld  = 1'b1;
                state_d = ST_XFER3;
            end
            ST_XFER3: begin
                xbus    = tmp_q;
                wr_vld  = 1'b1;
                state_d = ST_DONE;
            end
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // At most one register written per edge, and none for an illegal command.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_en[i] = wr_vld && !cmd_ill && (wr_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= bif.cmd_op;
                dst_q  <= bif.cmd_dst;
                src_q  <= bif.cmd_src;
                data_q <= bif.data_in;
            end
        end
    end

`ifdef REGBANK_SWAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmp_q <= '0;
        end else if (tmp_ld) begin
            tmp_q <= xbus;
        end
    end
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        regbank_cell #(.WIDTH(WIDTH)) u_cell (
            .clk      (clk),
            .rst_n    (reset),
            .ld_en_i  (wr_en[g]),
            .ld_dat_i (xbus),
            .q_o      (regs[g])
        );
    end

endmodule
